// File: rtl/noc_output_port_pkg.sv
// Shared flit type codes, FSM state and sticky error layout for the NoC output port.
package noc_output_port_pkg;

  localparam int unsigned TYPE_W = 3;

  localparam logic [TYPE_W-1:0] FLIT_HDR  = 3'b001;
  localparam logic [TYPE_W-1:0] FLIT_TAIL = 3'b100;
  localparam logic [TYPE_W-1:0] FLIT_HT   = 3'b101;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  typedef struct packed {
    logic proto;     // header seen inside a locked packet
    logic cred_ovf;  // credit return while already full
  } err_t;

  function automatic logic is_head(input logic [TYPE_W-1:0] t);
    return (t == FLIT_HDR) || (t == FLIT_HT);
  endfunction

endpackage

// File: rtl/noc_output_port_rr_arbiter.sv
// Combinational round-robin arbiter: first request strictly after ptr_i, wrapping.
module noc_output_port_rr_arbiter #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 any_o
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W:0]   shift;
  logic [2*N-1:0]   req_rot2;
  logic [N-1:0]     req_rot;
  logic [N-1:0]     first_rot;
  logic [2*N-1:0]   gnt_rot2;

  // Rotate so ptr+1 lands on bit 0, take the lowest set bit, rotate back.
  assign shift     = {1'b0, ptr_i} + (IDX_W+1)'(1);
  assign req_rot2  = {req_i, req_i} >> shift;
  assign req_rot   = req_rot2[N-1:0];
  assign first_rot = req_rot & (~req_rot + N'(1));
  assign gnt_rot2  = {first_rot, first_rot} << shift;
  assign gnt_o     = gnt_rot2[2*N-1:N];
  assign any_o     = |req_i;

  always_comb begin
    gnt_idx_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_o == (N'(1) << i)) gnt_idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/noc_output_port.sv
// Router output port: packet-locked round-robin arbitration, crossbar mux,
// registered output flit and credit-based flow control toward the next hop.
module noc_output_port
  import noc_output_port_pkg::*;
#(
  parameter int unsigned NPORTS     = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CREDITS    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NPORTS-1:0]            in_valid_i,
  input  logic [NPORTS-1:0]            in_req_i,
  input  logic [NPORTS*DATA_WIDTH-1:0] in_data_i,
  output logic [NPORTS-1:0]            in_rd_o,
  output logic [DATA_WIDTH-1:0]        tx_o,
  output logic                         rts_o,
  input  logic                         dcts_i,
  output logic [$clog2(NPORTS)-1:0]    owner_o,
  output logic                         busy_o,
  output logic [1:0]                   err_o
);

  localparam int unsigned CRED_W   = $clog2(CREDITS + 1);
  localparam int unsigned IDX_W    = $clog2(NPORTS);
  localparam int unsigned TYPE_MSB = DATA_WIDTH - 1;

  state_e                  state_q;
  logic [IDX_W-1:0]        rr_ptr_q;
  logic [IDX_W-1:0]        owner_q;
  logic [CRED_W-1:0]       credits_q;
  logic [DATA_WIDTH-1:0]   tx_q;
  logic                    rts_q;
  err_t                    err_q;

  logic [DATA_WIDTH-1:0]   flit [NPORTS];
  logic [NPORTS-1:0]       cand;
  logic [NPORTS-1:0]       arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;
  logic                    can_send;
  logic                    send_c;
  logic [IDX_W-1:0]        sel;
  logic [DATA_WIDTH-1:0]   sel_flit;
  logic [TYPE_W-1:0]       sel_type;

  // Head-flit slices and packet-start candidates per input.
  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    assign flit[g] = in_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign cand[g] = in_valid_i[g] & in_req_i[g] & is_head(flit[g][TYPE_MSB -: TYPE_W]);
  end

  noc_output_port_rr_arbiter #(
    .N (NPORTS)
  ) u_arb (
    .req_i     (cand),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  assign can_send = (credits_q != '0);
  assign sel_flit = flit[sel];
  assign sel_type = sel_flit[TYPE_MSB -: TYPE_W];

  // Pop/send decision; no pops at all while reset is asserted.
  always_comb begin
    in_rd_o = '0;
    send_c  = 1'b0;
    sel     = owner_q;
    if (rst_ni && can_send) begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            send_c  = 1'b1;
            sel     = arb_idx;
            in_rd_o = arb_gnt;
          end
        end
        ST_LOCKED: begin
          if (in_valid_i[owner_q]) begin
            send_c           = 1'b1;
            in_rd_o[owner_q] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      credits_q <= CRED_W'(CREDITS);
      tx_q      <= '0;
      rts_q     <= 1'b0;
      err_q     <= '0;
    end else begin
      rts_q <= send_c;
      if (send_c) tx_q <= sel_flit;

      // A send and a credit return in the same cycle cancel out.
      if (send_c && !dcts_i) begin
        credits_q <= credits_q - CRED_W'(1);
      end else if (!send_c && dcts_i) begin
        if (credits_q == CRED_W'(CREDITS)) err_q.cred_ovf <= 1'b1;
        else                               credits_q <= credits_q + CRED_W'(1);
      end

      if (send_c) begin
        case (state_q)
          ST_IDLE: begin
            rr_ptr_q <= sel;
            if (sel_type == FLIT_HDR) begin
              state_q <= ST_LOCKED;
              owner_q <= sel;
            end
          end
          ST_LOCKED: begin
            if (sel_type == FLIT_TAIL) begin
              state_q <= ST_IDLE;
            end else if (is_head(sel_type)) begin
              err_q.proto <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx_o    = tx_q;
  assign rts_o   = rts_q;
  assign owner_o = owner_q;
  assign busy_o  = (state_q == ST_LOCKED);
  assign err_o   = err_q;

endmodule
